// File: rtl/axis_axil_master.sv
// Byte-stream to AXI-Lite bridge: parses opcode/address/data bytes, issues one
// AXI-Lite transaction at a time and streams back a status byte plus read data.
module axis_axil_master #(
  parameter int AXIL_ADDR_WIDTH = 32,
  parameter int AXIL_DATA_WIDTH = 32
) (
  input  logic                         clk_i,
  input  logic                         arst_i,
  input  logic [7:0]                   s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [7:0]                   m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast,
  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic                         m_axil_awvalid,
  input  logic                         m_axil_awready,
  output logic [AXIL_DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                         m_axil_wvalid,
  input  logic                         m_axil_wready,
  input  logic [1:0]                   m_axil_bresp,
  input  logic                         m_axil_bvalid,
  output logic                         m_axil_bready,
  output logic [AXIL_ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic                         m_axil_arvalid,
  input  logic                         m_axil_arready,
  input  logic [AXIL_DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]                   m_axil_rresp,
  input  logic                         m_axil_rvalid,
  output logic                         m_axil_rready
);

  localparam int AB   = AXIL_ADDR_WIDTH / 8;
  localparam int DB   = AXIL_DATA_WIDTH / 8;
  localparam int MAXB = (AB > DB) ? AB : DB;
  localparam int CW   = $clog2(MAXB) + 1;
  localparam logic [CW-1:0] AB_LAST = CW'(AB - 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_DATA, S_WR_REQ, S_WR_RESP,
    S_RD_REQ, S_RD_RESP, S_TX_STAT, S_TX_DATA
  } state_t;

  state_t                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         is_rd_q, is_rd_d;
  logic [AXIL_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [AXIL_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [AXIL_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [7:0]                   stat_q, stat_d;
  logic                         aw_done_q, aw_done_d;
  logic                         w_done_q, w_done_d;
  logic                         s_fire, m_fire, aw_ok, w_ok;

  // Input is gated by reset so no byte can be taken while the bridge is held.
  assign s_axis_tready = !arst_i &&
                         (state_q == S_IDLE || state_q == S_ADDR || state_q == S_DATA);
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  assign m_axis_tvalid = (state_q == S_TX_STAT) || (state_q == S_TX_DATA);
  assign m_fire        = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = (state_q == S_TX_DATA) ? rdata_q[AXIL_DATA_WIDTH-1 -: 8] : stat_q;
  assign m_axis_tlast  = (state_q == S_TX_STAT && !is_rd_q) ||
                         (state_q == S_TX_DATA && cnt_q == DB_LAST);

  assign m_axil_awaddr  = addr_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = '1;
  assign m_axil_awvalid = (state_q == S_WR_REQ) && !aw_done_q;
  assign m_axil_wvalid  = (state_q == S_WR_REQ) && !w_done_q;
  assign m_axil_bready  = (state_q == S_WR_RESP);
  assign m_axil_arvalid = (state_q == S_RD_REQ);
  assign m_axil_rready  = (state_q == S_RD_RESP);

  assign aw_ok = aw_done_q || m_axil_awready;
  assign w_ok  = w_done_q || m_axil_wready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    stat_d    = stat_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    case (state_q)
      S_IDLE: begin
        if (s_fire) begin
          if (s_axis_tdata == 8'h01 || s_axis_tdata == 8'h02) begin
            is_rd_d = (s_axis_tdata == 8'h02);
            state_d = S_ADDR;
          end else begin
            is_rd_d = 1'b0;
            stat_d  = 8'hFF;
            state_d = S_TX_STAT;
          end
        end
      end
      S_ADDR: begin
        if (s_fire) begin
          addr_d = (addr_q << 8) | AXIL_ADDR_WIDTH'(s_axis_tdata);
          if (cnt_q == AB_LAST) state_d = is_rd_q ? S_RD_REQ : S_DATA;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (s_fire) begin
          wdata_d = (wdata_q << 8) | AXIL_DATA_WIDTH'(s_axis_tdata);
          if (cnt_q == DB_LAST) state_d = S_WR_REQ;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      S_WR_REQ: begin
        // Address and data channels complete independently, in either order.
        aw_done_d = aw_ok;
        w_done_d  = w_ok;
        if (aw_ok && w_ok) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m_axil_bvalid) begin
          stat_d  = {6'b0, m_axil_bresp};
          state_d = S_TX_STAT;
        end
      end
      S_RD_REQ: begin
        if (m_axil_arready) state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (m_axil_rvalid) begin
          rdata_d = m_axil_rdata;
          stat_d  = {6'b0, m_axil_rresp};
          state_d = S_TX_STAT;
        end
      end
      S_TX_STAT: begin
        if (m_fire) state_d = is_rd_q ? S_TX_DATA : S_IDLE;
      end
      S_TX_DATA: begin
        // Shift so the next byte always sits at the top; stable while stalled.
        if (m_fire) begin
          rdata_d = rdata_q << 8;
          if (cnt_q == DB_LAST) state_d = S_IDLE;
          else                  cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_rd_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      stat_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      stat_q    <= stat_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: doc/axis_axil_master.md
AXIS_AXIL_MASTER -- requirements
Module: axis_axil_master

Interface
REQ-001 SHALL have parameter AXIL_ADDR_WIDTH, default 32: AXI-Lite address width, a multiple of 8.
REQ-002 SHALL have parameter AXIL_DATA_WIDTH, default 32: AXI-Lite data width, 32 or 64.
REQ-003 SHALL have ports clk_i in 1 (single clock) and arst_i in 1 (reset, asynchronous, active-high).
REQ-004 SHALL have ports s_axis_tdata in 8, s_axis_tvalid in 1 and s_axis_tready out 1: command byte stream.
REQ-005 SHALL have ports m_axis_tdata out 8, m_axis_tvalid out 1, m_axis_tready in 1 and m_axis_tlast out 1: response byte stream.
REQ-006 SHALL have write-address ports m_axil_awaddr out AXIL_ADDR_WIDTH, m_axil_awvalid out 1 and m_axil_awready in 1.
REQ-007 SHALL have write-data ports m_axil_wdata out AXIL_DATA_WIDTH, m_axil_wstrb out AXIL_DATA_WIDTH/8, m_axil_wvalid out 1 and m_axil_wready in 1.
REQ-008 SHALL have write-response ports m_axil_bresp in 2, m_axil_bvalid in 1 and m_axil_bready out 1.
REQ-009 SHALL have read-address ports m_axil_araddr out AXIL_ADDR_WIDTH, m_axil_arvalid out 1 and m_axil_arready in 1.
REQ-010 SHALL have read-data ports m_axil_rdata in AXIL_DATA_WIDTH, m_axil_rresp in 2, m_axil_rvalid in 1 and m_axil_rready out 1.

Function
REQ-011 SHALL act as the AXI-Lite initiator (master), converting byte commands into single AXI-Lite transactions, one outstanding at a time.
REQ-012 SHALL use command framing: opcode byte, then AB=AXIL_ADDR_WIDTH/8 address bytes MSB first; opcode 0x01 (write) is followed by DB=AXIL_DATA_WIDTH/8 data bytes MSB first; opcode 0x02 is a read.
REQ-013 SHALL assert s_axis_tready only in states IDLE, ADDR and DATA; each byte is accepted on tvalid&&tready.
REQ-014 SHALL implement states IDLE -> ADDR -> (DATA if write) -> WR_REQ -> WR_RESP -> TX_STAT, or IDLE -> ADDR -> RD_REQ -> RD_RESP -> TX_STAT -> TX_DATA -> IDLE.
REQ-015 SHALL, in IDLE, consume an unknown opcode and go to TX_STAT with status 0xFF, sending the status byte only, tlast=1.
REQ-016 SHALL, in WR_REQ, assert awvalid and wvalid together, drop each independently after its own handshake, and leave the state when both are done, in any order or in the same cycle.
REQ-017 SHALL drive wstrb all-ones, and keep awaddr, wdata and araddr stable while the matching valid is high.
REQ-018 SHALL hold bready=1 only in WR_RESP and capture bresp on bvalid; SHALL hold rready=1 only in RD_RESP and capture rdata and rresp on rvalid.
REQ-019 SHALL, in RD_REQ, hold arvalid until arready; a handshake in the first cycle moves to RD_RESP on the next edge.
REQ-020 SHALL send the status byte {6'b0, resp}, followed for reads by DB rdata bytes MSB first; tlast=1 on the final byte of each response.
REQ-021 SHALL hold m_axis_tdata and m_axis_tlast stable while tvalid=1 and tready=0, and SHALL not deassert tvalid before the handshake.
REQ-022 SHALL return to IDLE in the cycle after the last response byte handshakes; no valid may be asserted for the next command before that edge.
REQ-023 SHALL return SLVERR/DECERR codes as data without retry.
REQ-024 SHALL count bytes with a counter of width clog2(max(AB,DB))+1 that resets to 0 on every state entry.

Reset
REQ-025 SHALL, while arst_i=1, force state IDLE, all AXI valids and readies low, s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, and all address, data and count registers to 0.
REQ-026 SHALL assert s_axis_tready in the first cycle after arst_i deasserts, and SHALL discard a partly received command or a pending transaction when reset is asserted mid-operation.

Verification
REQ-027 SHALL be verified by a write: bytes 01 00 00 00 10 DE AD BE EF -> awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF; bresp=0 -> response 0x00 with tlast.
REQ-028 SHALL be verified by a read: bytes 02 00 00 00 20 with rdata=0x12345678, rresp=0 -> response 00 12 34 56 78, tlast on 0x78.
REQ-029 SHALL be verified by a write with wready 3 cycles after awready, then with both in the same cycle -> exactly one handshake each, bready asserted only afterward.
REQ-030 SHALL be verified by opcode 0x7E -> single byte 0xFF, tlast=1, no AXI valid asserted.
REQ-031 SHALL be verified by a read with rresp=2 and m_axis_tready toggling every cycle -> 02 then four data bytes, stable while stalled.
REQ-032 SHALL be verified by arst_i pulsed after 3 address bytes -> all outputs at reset values; the next full command completes normally.
